// File: rtl/lm_sm_sequencer.sv
// LM/SM sequencer: holds IF/ID and the PC while a load/store-multiple is
// expanded into one single-register micro-op per set bit of its register list.
module lm_sm_sequencer #(
  parameter logic [3:0] LM_OPCODE = 4'b0110,
  parameter logic [3:0] SM_OPCODE = 4'b0111
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [15:0] inst,
  input  logic        valid,
  input  logic        flush,
  input  logic        id_ready,
  output logic        ifid_hold,
  output logic        pc_hold,
  output logic        seq_active,
  output logic        uop_valid,
  output logic        uop_is_store,
  output logic [2:0]  uop_base,
  output logic [2:0]  uop_reg,
  output logic [2:0]  uop_offset,
  output logic        uop_last
);

  typedef enum logic {IDLE, SEQ} state_t;

  state_t     state_reg, state_next;
  logic [7:0] pending_reg, pending_next;
  logic [2:0] base_reg, base_next;
  logic       store_reg, store_next;
  logic [2:0] count_reg, count_next;

  logic       is_lm_sm;
  logic       detect;
  logic       transfer;
  logic       one_left;
  logic       hold_comb;
  logic [7:0] below;
  logic [7:0] lowest_onehot;
  logic       unused_inst_bit;

  assign unused_inst_bit = inst[8];

  assign is_lm_sm = (inst[15:12] == LM_OPCODE) || (inst[15:12] == SM_OPCODE);
  assign detect   = valid && !flush && is_lm_sm && (inst[7:0] != 8'd0);

  // Isolate the lowest pending bit: a bit wins if nothing below it is pending.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi = gi + 1) begin : g_lowest
      if (gi == 0) begin : g_first
        assign below[gi] = 1'b0;
      end else begin : g_rest
        assign below[gi] = |pending_reg[gi-1:0];
      end
      assign lowest_onehot[gi] = pending_reg[gi] & ~below[gi];
    end
  endgenerate

  assign uop_reg[0] = |(lowest_onehot & 8'b1010_1010);
  assign uop_reg[1] = |(lowest_onehot & 8'b1100_1100);
  assign uop_reg[2] = |(lowest_onehot & 8'b1111_0000);

  assign one_left     = (pending_reg != 8'd0) && ((pending_reg & (pending_reg - 8'd1)) == 8'd0);
  assign seq_active   = (state_reg == SEQ);
  assign uop_valid    = seq_active && !flush;
  assign uop_last     = seq_active && one_left;
  assign uop_base     = base_reg;
  assign uop_offset   = count_reg;
  assign uop_is_store = store_reg;
  assign transfer     = uop_valid && id_ready;

  // Hold is forced low while reset is asserted so the pipeline is never frozen by it.
  assign ifid_hold = hold_comb && reset_n;
  assign pc_hold   = ifid_hold;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= IDLE;
      pending_reg <= 8'd0;
      base_reg    <= 3'd0;
      store_reg   <= 1'b0;
      count_reg   <= 3'd0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      base_reg    <= base_next;
      store_reg   <= store_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    base_next    = base_reg;
    store_next   = store_reg;
    count_next   = count_reg;
    hold_comb    = 1'b0;

    case (state_reg)
      IDLE: begin
        hold_comb = detect;
        if (detect) begin
          pending_next = inst[7:0];
          base_next    = inst[11:9];
          store_next   = (inst[15:12] == SM_OPCODE);
          count_next   = 3'd0;
          state_next   = SEQ;
        end
      end
      SEQ: begin
        // Dropping hold on the final accept lets IF/ID load the next instruction on that edge.
        hold_comb = !flush && !(transfer && one_left);
        if (transfer) begin
          if (one_left) begin
            state_next   = IDLE;
            pending_next = 8'd0;
            base_next    = 3'd0;
            store_next   = 1'b0;
            count_next   = 3'd0;
          end else begin
            pending_next = pending_reg & ~lowest_onehot;
            count_next   = count_reg + 3'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    if (flush) begin
      state_next   = IDLE;
      pending_next = 8'd0;
      base_next    = 3'd0;
      store_next   = 1'b0;
      count_next   = 3'd0;
    end
  end

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// Bench for lm_sm_sequencer: a queue-based model checked every falling edge,
// plus directed scenarios with hand-computed literal expectations.
module tb_lm_sm_sequencer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] inst = 16'h0000;
  logic        valid = 1'b0;
  logic        flush = 1'b0;
  logic        id_ready = 1'b1;
  logic        ifid_hold, pc_hold, seq_active, uop_valid, uop_is_store, uop_last;
  logic [2:0]  uop_base, uop_reg, uop_offset;

  int n_cmp = 0;
  int n_bad = 0;

  lm_sm_sequencer dut (
    .clock(clock), .reset_n(reset_n), .inst(inst), .valid(valid), .flush(flush),
    .id_ready(id_ready), .ifid_hold(ifid_hold), .pc_hold(pc_hold),
    .seq_active(seq_active), .uop_valid(uop_valid), .uop_is_store(uop_is_store),
    .uop_base(uop_base), .uop_reg(uop_reg), .uop_offset(uop_offset), .uop_last(uop_last)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model: the pending instruction is a queue of register indices, lowest first.
  bit  m_active = 0;
  int  m_q[$];
  int  m_count = 0;
  int  m_base = 0;
  bit  m_store = 0;

  function automatic bit m_detect();
    return valid && !flush && (inst[15:12] == 4'd6 || inst[15:12] == 4'd7) && (inst[7:0] != 8'd0);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_active = 0; m_q.delete(); m_count = 0; m_base = 0; m_store = 0;
    end else if (flush) begin
      m_active = 0; m_q.delete(); m_count = 0; m_base = 0; m_store = 0;
    end else if (!m_active) begin
      if (m_detect()) begin
        for (int i = 0; i < 8; i++) if (inst[i]) m_q.push_back(i);
        m_count = 0; m_base = int'(inst[11:9]); m_store = (inst[15:12] == 4'd7);
        m_active = 1;
      end
    end else if (id_ready) begin
      void'(m_q.pop_front());
      m_count++;
      if (m_q.size() == 0) begin
        m_active = 0; m_count = 0; m_base = 0; m_store = 0;
      end
    end
  end

  always @(negedge clock) begin
    int e_hold, e_seq, e_v, e_st, e_base, e_reg, e_off, e_last;
    e_hold = 0; e_seq = 0; e_v = 0; e_st = 0; e_base = 0; e_reg = 0; e_off = 0; e_last = 0;
    if (reset_n) begin
      if (!m_active) begin
        e_hold = int'(m_detect());
      end else begin
        e_seq  = 1;
        e_v    = !flush;
        e_st   = m_store;
        e_base = m_base;
        e_reg  = m_q[0];
        e_off  = m_count;
        e_last = (m_q.size() == 1);
        e_hold = (flush || (id_ready && e_last)) ? 0 : 1;
        if (e_v && id_ready)
          $display("uop %s R%0d base=R%0d off=%0d last=%0d",
                   m_store ? "SM" : "LM", e_reg, e_base, e_off, e_last);
      end
    end
    chk("model ifid_hold", int'(ifid_hold), e_hold);
    chk("model pc_hold", int'(pc_hold), e_hold);
    chk("model seq_active", int'(seq_active), e_seq);
    chk("model uop_valid", int'(uop_valid), e_v);
    chk("model uop_is_store", int'(uop_is_store), e_st);
    chk("model uop_base", int'(uop_base), e_base);
    chk("model uop_reg", int'(uop_reg), e_reg);
    chk("model uop_offset", int'(uop_offset), e_off);
    chk("model uop_last", int'(uop_last), e_last);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk_uop(input string name, input int r, input int off, input int last, input int hold);
    chk({name, " uop_valid"}, int'(uop_valid), 1);
    chk({name, " uop_reg"}, int'(uop_reg), r);
    chk({name, " uop_offset"}, int'(uop_offset), off);
    chk({name, " uop_last"}, int'(uop_last), last);
    chk({name, " ifid_hold"}, int'(ifid_hold), hold);
  endtask

  task automatic chk_quiet(input string name);
    chk({name, " ifid_hold"}, int'(ifid_hold), 0);
    chk({name, " uop_valid"}, int'(uop_valid), 0);
    chk({name, " seq_active"}, int'(seq_active), 0);
  endtask

  initial begin
    int hold_cycles;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    chk_quiet("reset");
    chk("reset uop_last", int'(uop_last), 0);
    reset_n = 1'b1;
    tick();

    // LM Ra=2, list 00100101
    $display("txn LM base=R2 list=00100101");
    inst = {4'b0110, 3'd2, 1'b0, 8'b0010_0101}; valid = 1'b1; id_ready = 1'b1;
    settle();
    chk("lmA c0 ifid_hold", int'(ifid_hold), 1);
    chk("lmA c0 seq_active", int'(seq_active), 0);
    tick(); settle();
    chk_uop("lmA c1", 0, 0, 0, 1);
    chk("lmA c1 uop_is_store", int'(uop_is_store), 0);
    chk("lmA c1 uop_base", int'(uop_base), 2);
    tick(); settle();
    chk_uop("lmA c2", 2, 1, 0, 1);
    tick(); settle();
    chk_uop("lmA c3", 5, 2, 1, 0);
    tick();
    valid = 1'b0; inst = 16'h0000;
    settle();
    chk("lmA c4 seq_active", int'(seq_active), 0);

    // SM list FF: R0..R7, offsets 0..7, hold high 8 cycles
    tick();
    $display("txn SM base=R1 list=11111111");
    inst = {4'b0111, 3'd1, 1'b0, 8'hFF}; valid = 1'b1;
    hold_cycles = 0;
    for (int k = 0; k <= 8; k++) begin
      settle();
      if (ifid_hold) hold_cycles++;
      if (k >= 1) begin
        chk_uop("smFF", k - 1, k - 1, (k == 8) ? 1 : 0, (k == 8) ? 0 : 1);
        chk("smFF uop_is_store", int'(uop_is_store), 1);
      end
      tick();
    end
    valid = 1'b0; inst = 16'h0000;
    chk("smFF hold cycles", hold_cycles, 8);

    // Backpressure: SM list 00000011
    tick();
    $display("txn SM base=R0 list=00000011 backpressure");
    inst = {4'b0111, 3'd0, 1'b0, 8'b0000_0011}; valid = 1'b1;
    settle();
    tick();
    id_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      settle();
      chk_uop("bp stall", 0, 0, 0, 1);
      tick();
    end
    id_ready = 1'b1;
    settle();
    chk_uop("bp accept0", 0, 0, 0, 1);
    tick(); settle();
    chk_uop("bp accept1", 1, 1, 1, 0);
    tick();
    valid = 1'b0; inst = 16'h0000;

    // Flush during second micro-op: LM list 11110000
    tick();
    $display("txn LM base=R3 list=11110000 flush");
    inst = {4'b0110, 3'd3, 1'b0, 8'b1111_0000}; valid = 1'b1;
    settle();
    tick(); settle();
    chk_uop("fl c1", 4, 0, 0, 1);
    tick();
    flush = 1'b1;
    settle();
    chk("fl c2 uop_valid", int'(uop_valid), 0);
    chk("fl c2 ifid_hold", int'(ifid_hold), 0);
    chk("fl c2 uop_reg", int'(uop_reg), 5);
    tick();
    flush = 1'b0; valid = 1'b0; inst = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk_quiet("fl after");
      tick();
    end

    // Empty list, non-LM/SM opcode, and flush masking detection in IDLE
    $display("txn LM empty list / opcode 0 / flushed LM");
    inst = {4'b0110, 3'd1, 1'b0, 8'h00}; valid = 1'b1;
    for (int k = 0; k < 2; k++) begin settle(); chk_quiet("empty"); tick(); end
    inst = 16'h00FF;
    for (int k = 0; k < 2; k++) begin settle(); chk_quiet("nonlm"); tick(); end
    inst = {4'b0111, 3'd1, 1'b0, 8'h0F}; flush = 1'b1;
    for (int k = 0; k < 2; k++) begin settle(); chk_quiet("flushidle"); tick(); end
    flush = 1'b0; valid = 1'b0;

    // Reset mid-sequence: LM R1, list FF, reset after 3 micro-ops
    tick();
    $display("txn LM base=R1 list=11111111 reset");
    inst = {4'b0110, 3'd1, 1'b0, 8'hFF}; valid = 1'b1;
    settle();
    repeat (4) tick();
    settle();
    chk_uop("rst before", 3, 3, 0, 1);
    reset_n = 1'b0; valid = 1'b0;
    #1;
    chk_quiet("rst async");
    chk("rst async uop_last", int'(uop_last), 0);
    chk("rst async pc_hold", int'(pc_hold), 0);
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin settle(); chk_quiet("rst after"); tick(); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
